// File: rtl/memory_game_pkg.sv
// Shared constants, secret sequence and FSM state type for the memory game.
package memory_game_pkg;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 10;
    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Entry 0 sits in the least significant nibble.
    localparam logic [DEPTH-1:0][DATA_W-1:0] ROM_INIT = {
        4'b0111, 4'b1000, 4'b0001, 4'b1111, 4'b1001,
        4'b0101, 4'b1100, 4'b0011, 4'b0110, 4'b1010
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/memory_game_rom.sv
// Synchronous-read secret sequence ROM; registered output maps onto block RAM.
module memory_game_rom
    import memory_game_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        data <= ROM_INIT[addr];
    end

endmodule

// File: rtl/memory_game_top.sv
// Memory game: synchronised button/switches, one evaluation per press, LEDs show last verdict.
module memory_game_top
    import memory_game_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] switches,
    input  logic              btn0,
    output logic              led0,
    output logic              led1
);

    logic [1:0]        btn_sync;
    logic              btn_prev;
    logic [DATA_W-1:0] sw_s1;
    logic [DATA_W-1:0] sw_s2;
    logic              press;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] rom_data;
    logic              hit;
    state_t            state;
    state_t            state_next;

    memory_game_rom u_rom (
        .clk  (clk),
        .addr (address),
        .data (rom_data)
    );

    // Switches ride the same two-flop path as the button so both land together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= '0;
            btn_prev <= 1'b0;
            sw_s1    <= '0;
            sw_s2    <= '0;
        end else begin
            btn_sync <= {btn_sync[0], btn0};
            btn_prev <= btn_sync[1];
            sw_s1    <= switches;
            sw_s2    <= sw_s1;
        end
    end

    assign press = btn_sync[1] & ~btn_prev;
    assign hit   = (sw_s2 == rom_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Presses seen outside IDLE are dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (press) state_next = EVAL;
            EVAL:    state_next = SETTLE;
            SETTLE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address <= '0;
            led0    <= 1'b0;
            led1    <= 1'b0;
        end else if (state == EVAL) begin
            led0 <= hit;
            led1 <= ~hit;
            if (hit) address <= (address == LAST_ADDR) ? '0 : address + 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_game_top.sv
// Self-checking bench for memory_game_top: directed table, reset corners, random presses vs model.
module tb_memory_game_top;

    logic       clk;
    logic       rst_n;
    logic [3:0] switches;
    logic       btn0;
    logic       led0;
    logic       led1;

    int total = 0;
    int bad   = 0;

    // Reference model: secret list plus current position.
    int secret [10] = '{10, 6, 3, 12, 5, 9, 15, 1, 8, 7};
    int model_pos;

    typedef struct {
        logic [3:0] sw;
        int         hold;
        logic       exp_led0;
        logic       exp_led1;
        int         exp_addr;
    } vec_t;

    vec_t vecs [15];

    memory_game_top dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .switches (switches),
        .btn0     (btn0),
        .led0     (led0),
        .led1     (led1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Press for `hold` cycles; LEDs checked 4 cycles after rise, address after settle.
    task automatic press(input string name, input logic [3:0] sw, input int hold,
                         input logic e0, input logic e1, input int eaddr);
        int last;
        last = (hold > 4) ? hold : 4;
        @(negedge clk);
        switches = sw;
        btn0     = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == hold) btn0 = 1'b0;
            if (c == 4) begin
                check({name, ".led0"}, int'(led0), int'(e0));
                check({name, ".led1"}, int'(led1), int'(e1));
            end
        end
        repeat (4) @(negedge clk);
        check({name, ".addr"}, int'(dut.address), eaddr);
        check({name, ".led0_hold"}, int'(led0), int'(e0));
        check({name, ".led_excl"}, int'(led0 & led1), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn0  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [3:0] sw;
        int         hold;
        logic       hit;

        vecs[0]  = '{4'b1010, 2,  1'b1, 1'b0, 1};
        vecs[1]  = '{4'b0000, 2,  1'b0, 1'b1, 1};
        vecs[2]  = '{4'b0110, 2,  1'b1, 1'b0, 2};
        vecs[3]  = '{4'b0011, 3,  1'b1, 1'b0, 3};
        vecs[4]  = '{4'b1100, 2,  1'b1, 1'b0, 4};
        vecs[5]  = '{4'b0101, 5,  1'b1, 1'b0, 5};
        vecs[6]  = '{4'b1001, 2,  1'b1, 1'b0, 6};
        vecs[7]  = '{4'b1111, 2,  1'b1, 1'b0, 7};
        vecs[8]  = '{4'b0001, 2,  1'b1, 1'b0, 8};
        vecs[9]  = '{4'b1000, 2,  1'b1, 1'b0, 9};
        vecs[10] = '{4'b0111, 2,  1'b1, 1'b0, 0};
        vecs[11] = '{4'b1010, 2,  1'b1, 1'b0, 1};
        vecs[12] = '{4'b0000, 50, 1'b0, 1'b1, 1};
        vecs[13] = '{4'b0110, 50, 1'b1, 1'b0, 2};
        vecs[14] = '{4'b0011, 2,  1'b1, 1'b0, 3};

        switches = '0;
        btn0     = 1'b0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.led0", int'(led0), 0);
        check("reset.led1", int'(led1), 0);
        check("reset.addr", int'(dut.address), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle.led0", int'(led0), 0);
        check("idle.led1", int'(led1), 0);
        check("idle.addr", int'(dut.address), 0);

        foreach (vecs[i])
            press($sformatf("vec%0d", i), vecs[i].sw, vecs[i].hold,
                  vecs[i].exp_led0, vecs[i].exp_led1, vecs[i].exp_addr);

        // Reset after three correct guesses clears LEDs and progress.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midgame_rst.led0", int'(led0), 0);
        check("midgame_rst.led1", int'(led1), 0);
        check("midgame_rst.addr", int'(dut.address), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        press("after_rst", 4'b1010, 2, 1'b1, 1'b0, 1);

        // Reset while the press is being evaluated discards the verdict.
        @(negedge clk);
        switches = 4'b0110;
        btn0     = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        btn0  = 1'b0;
        repeat (2) @(negedge clk);
        check("evalrst.led0", int'(led0), 0);
        check("evalrst.led1", int'(led1), 0);
        check("evalrst.addr", int'(dut.address), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("evalrst_idle.led0", int'(led0), 0);
        check("evalrst_idle.addr", int'(dut.address), 0);

        // Random play against the reference model.
        model_pos = 0;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(1, 0) == 1) sw = 4'(secret[model_pos]);
            else                           sw = 4'($urandom_range(15, 0));
            hold = $urandom_range(8, 2);
            hit  = (int'(sw) == secret[model_pos]);
            if (hit) model_pos = (model_pos + 1) % 10;
            press($sformatf("rnd%0d", n), sw, hold, hit, ~hit, model_pos);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
